// File: rtl/count_pkg.sv
// Shared types and defaults for the skip-count sequencer scheduler.
package count_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int W_DEF  = 5;
  localparam int LO_DEF = 2;

endpackage

// File: rtl/count_next.sv
// Combinational skip-count step: wraps at MAX, +2 strictly between LO and MAX, +1 otherwise.
module count_next
  import count_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int LO = LO_DEF
) (
  input  logic [W-1:0] q,
  output logic [W-1:0] q_next
);

  localparam logic [W-1:0] MAX  = '1;
  localparam logic [W-1:0] LO_V = W'(LO);

  always_comb begin
    if (q == MAX) begin
      q_next = '0;
    end else if (q > LO_V) begin
      q_next = q + W'(2);
    end else begin
      q_next = q + W'(1);
    end
  end

endmodule

// File: rtl/count_seq_sched.sv
// Two-requester scheduler sharing one skip-count sequencer over a valid/ready stream.
// Build option: define COUNT_SCHED_RR_EN for round-robin arbitration (default: requester 0 wins).
module count_seq_sched
  import count_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int LO = LO_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_start,
  input  logic [W-1:0] req0_len,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_start,
  input  logic [W-1:0] req1_len,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_val,
  output logic         out_id,
  output logic         out_last,
  output logic         busy,
  output logic         done
);

  state_t       state;
  logic [W-1:0] cur;
  logic [W-1:0] rem;
  logic [W-1:0] cur_nxt;
  logic         id;
  logic         gnt_any;
  logic         gnt_id;
  logic [W-1:0] gnt_start;
  logic [W-1:0] gnt_len;

`ifdef COUNT_SCHED_RR_EN
  logic rr;

  // rr names the requester that wins the next contention
  always_comb begin
    if (req0_valid && req1_valid) begin
      gnt_id = rr;
    end else begin
      gnt_id = ~req0_valid;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr <= 1'b0;
    end else if (gnt_any) begin
      rr <= ~gnt_id;
    end
  end
`else
  assign gnt_id = ~req0_valid;
`endif

  // Grants only from IDLE, never while reset is held
  assign gnt_any    = (state == IDLE) && (req0_valid || req1_valid) && !rst;
  assign req0_ready = gnt_any && !gnt_id;
  assign req1_ready = gnt_any && gnt_id;
  assign gnt_start  = gnt_id ? req1_start : req0_start;
  assign gnt_len    = gnt_id ? req1_len   : req0_len;

  count_next #(.W(W), .LO(LO)) u_next (
    .q      (cur),
    .q_next (cur_nxt)
  );

  assign out_val = cur;
  assign out_id  = id;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cur       <= '0;
      rem       <= '0;
      id        <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (gnt_any) begin
            state     <= RUN;
            cur       <= gnt_start;
            rem       <= gnt_len;
            id        <= gnt_id;
            out_valid <= 1'b1;
            out_last  <= (gnt_len == '0);
            busy      <= 1'b1;
          end else begin
            busy <= 1'b0;
          end
        end
        RUN: begin
          if (out_ready) begin
            if (rem == '0) begin
              state     <= DONE;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              done      <= 1'b1;
            end else begin
              cur      <= cur_nxt;
              rem      <= rem - W'(1);
              out_last <= (rem == W'(1));
            end
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule
